// File: rtl/trig_pkg.sv
// Shared encodings for the capture trigger: trigger modes and FSM states.
package trig_pkg;

   typedef enum logic [1:0] {
      TRIG_IMM  = 2'd0,
      TRIG_LVL  = 2'd1,
      TRIG_RISE = 2'd2,
      TRIG_CHG  = 2'd3
   } trig_mode_t;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ARMED   = 2'd1,
      ST_CAPTURE = 2'd2,
      ST_DONE    = 2'd3
   } state_t;

endpackage

// File: rtl/trig_match.sv
// Combinational trigger detector: decides whether the current sample fires
// the trigger, given the previous sample and the selected mode.
module trig_match
   import trig_pkg::*;
#(
   parameter int LVDS_LEN = 8
) (
   input  logic [LVDS_LEN-1:0] data,
   input  logic [LVDS_LEN-1:0] prev,
   input  logic                prev_ok,
   input  logic [1:0]          mode,
   input  logic [LVDS_LEN-1:0] mask,
   input  logic [LVDS_LEN-1:0] value,
   output logic                hit
);

   logic m_cur;
   logic m_prev;
   logic changed;

   // Masked compares on the current and previous sample, then mode select.
   always_comb begin
      m_cur   = ((data ^ value) & mask) == '0;
      m_prev  = ((prev ^ value) & mask) == '0;
      changed = ((data ^ prev) & mask) != '0;
      hit     = 1'b0;
      case (trig_mode_t'(mode))
         TRIG_IMM:  hit = 1'b1;
         TRIG_LVL:  hit = m_cur;
         TRIG_RISE: hit = m_cur & prev_ok & ~m_prev;
         TRIG_CHG:  hit = prev_ok & changed;
         default:   hit = 1'b0;
      endcase
   end

endmodule

// File: rtl/capture_trigger.sv
// Trigger and capture gate: keeps a pre-trigger delay line of the sample
// stream and forwards only the window around the trigger sample.
module capture_trigger
   import trig_pkg::*;
#(
   parameter int LVDS_LEN  = 8,
   parameter int PRE_DEPTH = 16,
   parameter int CNT_LEN   = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                arm,
   input  logic                abort,
   input  logic [1:0]          trig_mode,
   input  logic [LVDS_LEN-1:0] trig_mask,
   input  logic [LVDS_LEN-1:0] trig_value,
   input  logic [CNT_LEN-1:0]  post_len,
   input  logic                valid_in,
   input  logic [LVDS_LEN-1:0] data_in,
   output logic                valid_out,
   output logic [LVDS_LEN-1:0] data_out,
   output logic                trig_out,
   output logic                busy,
   output logic                done
);

   localparam logic [CNT_LEN-1:0] PRE_CNT = CNT_LEN'(PRE_DEPTH);
   localparam logic [CNT_LEN-1:0] ONE_CNT = CNT_LEN'(1);

   logic [LVDS_LEN-1:0] line_data [PRE_DEPTH];
   logic                line_flag [PRE_DEPTH];
   logic [LVDS_LEN-1:0] prev;
   logic                prev_ok;
   logic                hit;

   state_t              state;
   state_t              next_state;
   logic [CNT_LEN-1:0]  cnt;
   logic [CNT_LEN-1:0]  cnt_next;
   logic [CNT_LEN-1:0]  len;
   logic [CNT_LEN-1:0]  len_next;
   logic                fwd;
   logic                fwd_trig;

   trig_match #(
      .LVDS_LEN (LVDS_LEN)
   ) u_match (
      .data    (data_in),
      .prev    (prev),
      .prev_ok (prev_ok),
      .mode    (trig_mode),
      .mask    (trig_mask),
      .value   (trig_value),
      .hit     (hit)
   );

   // Delay line and previous-sample register advance on every valid sample, in every state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < PRE_DEPTH; i++) begin
            line_data[i] <= '0;
            line_flag[i] <= 1'b0;
         end
         prev    <= '0;
         prev_ok <= 1'b0;
      end else if (valid_in) begin
         for (int i = PRE_DEPTH - 1; i > 0; i--) begin
            line_data[i] <= line_data[i-1];
            line_flag[i] <= line_flag[i-1];
         end
         line_data[0] <= data_in;
         line_flag[0] <= 1'b1;
         prev         <= data_in;
         prev_ok      <= 1'b1;
      end
   end

   // State, window counter and latched length registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         cnt   <= '0;
         len   <= '0;
      end else begin
         state <= next_state;
         cnt   <= cnt_next;
         len   <= len_next;
      end
   end

   // Next-state logic. cnt holds the advances still to forward after the current
   // one, so the window is PRE_DEPTH+len advances including the trigger advance;
   // the trigger sample reaches the tap when cnt equals len.
   always_comb begin
      next_state = state;
      cnt_next   = cnt;
      len_next   = len;
      fwd        = 1'b0;
      fwd_trig   = 1'b0;
      if (abort) begin
         next_state = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE, ST_DONE: begin
               if (arm) begin
                  next_state = ST_ARMED;
                  len_next   = (post_len == '0) ? ONE_CNT : post_len;
               end
            end
            ST_ARMED: begin
               if (valid_in && hit) begin
                  next_state = ST_CAPTURE;
                  fwd        = 1'b1;
                  cnt_next   = PRE_CNT + len - ONE_CNT;
               end
            end
            ST_CAPTURE: begin
               if (valid_in) begin
                  fwd      = 1'b1;
                  fwd_trig = (cnt == len);
                  cnt_next = cnt - ONE_CNT;
                  if (cnt == ONE_CNT) begin
                     next_state = ST_DONE;
                  end
               end
            end
            default: next_state = ST_IDLE;
         endcase
      end
   end

   // Output register: forwards the tap entry on window advances, empty entries suppressed.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_out <= 1'b0;
         data_out  <= '0;
         trig_out  <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         valid_out <= fwd & line_flag[PRE_DEPTH-1];
         trig_out  <= fwd & fwd_trig;
         if (fwd) begin
            data_out <= line_data[PRE_DEPTH-1];
         end
         busy <= (next_state == ST_ARMED) || (next_state == ST_CAPTURE);
         done <= (next_state == ST_DONE);
      end
   end

endmodule
